mul_float_normalize_round_pipe: RTL and testbench
=================================================

// Module: mul_float_normalize_round_pipe
// PURPOSE
//  Parametrised 2-stage normalize/round stage for the float multiplier pipeline.
//  Sits between the significand multiplier and the packer.
//  Takes the raw 2*FRACT_W-bit product, normalizes it by at most 1 bit, and rounds it in one of five modes, selected per transaction.
//  Produces the rounded significand, the adjusted exponent and an inexact flag.
//  Uses full valid/busy backpressure with bubble collapse; it does not use a global stall.
// PARAMETERS
//  FRACT_W   24  significand width incl. hidden bit; product input is 2*FRACT_W (min 4)
//  EXP_W     10  biased exponent width (extra headroom bits for downstream over/underflow checks)
//  EXCEPT_W  6   width of the exception side-band, passed through unmodified
// PORTS
//  iCLOCK            in   1           clock; all state on rising edge
//  iRESET_SYNC       in   1           synchronous reset, active-high
//  iDATA_VALID       in   1           input transaction valid
//  oDATA_BUSY        out  1           stage cannot accept input this cycle
//  iDATA_SIGN        in   1           result sign
//  iDATA_EXP         in   EXP_W       exponent before normalization
//  iDATA_FRACT       in   2*FRACT_W   raw product (MSB or MSB-1 is leading one)
//  iDATA_RMODE       in   3           0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE
//  iDATA_EXCEPT      in   EXCEPT_W    exception side-band
//  oDATA_VALID       out  1           output valid
//  iDATA_BUSY        in   1           downstream cannot accept
//  oDATA_SIGN        out  1           sign
//  oDATA_EXP         out  EXP_W       adjusted exponent
//  oDATA_FRACT       out  FRACT_W     rounded, normalized significand (MSB = hidden 1 unless input was 0)
//  oDATA_INEXACT     out  1           G|S nonzero, i.e. the result was rounded
//  oDATA_EXCEPT      out  EXCEPT_W    side-band, aligned with its data
// BEHAVIOUR
//  Reset:
//   - iRESET_SYNC high at a clock edge clears both stage valids and all data registers.
//   - Every output is therefore 0 after reset.
//   - Reset applied mid-flight drops the in-flight transactions and emits no partial output.
//  Handshake (F = FRACT_W, P = iDATA_FRACT):
//   - s2_en = !s2_valid | !iDATA_BUSY
//   - s1_en = !s1_valid | s2_en
//   - oDATA_BUSY = !s1_en (combinational)
//   - A transfer occurs on iDATA_VALID & !oDATA_BUSY; a data register loads only when its enable is high.
//   - Latency is 2 cycles when there is no backpressure; sustained throughput is 1 per clock.
//   - Bubbles collapse: an empty s2 takes s1 even while iDATA_BUSY is high.
//   - While oDATA_VALID & iDATA_BUSY, every output holds stable.
//   - Order is preserved; there is no loss and no duplication.
//  Stage 1, normalize:
//   - If P[2F-1]:
//     - sig = P[2F-1:F], L = P[F], G = P[F-1], S = |P[F-2:0]
//     - e1 = iDATA_EXP + 1
//   - Else:
//     - sig = P[2F-2:F-1], L = P[F-1], G = P[F-2], S = |P[F-3:0]
//     - e1 = iDATA_EXP
//   - Register sign, e1, sig, L, G, S, rmode and except.
//  Stage 2, round:
//   - Increment per mode:
//     - RNE: G&(L|S)
//     - RTZ: 0
//     - RDN: sign&(G|S)
//     - RUP: !sign&(G|S)
//     - RMM: G
//   - sum = {1'b0,sig} + inc.
//     - If sum[F] (carry), oDATA_FRACT = 1<<(F-1) and exp = e1+1.
//     - Otherwise oDATA_FRACT = sum[F-1:0] and exp = e1.
//   - oDATA_INEXACT = G|S, regardless of mode.
//   - Exponent arithmetic is modulo 2^EXP_W; this stage flags no overflow.
//   - A zero product gives fract 0, inexact 0, exp = iDATA_EXP.
// TESTING (F=24, EXP_W=10)
//  - 1.0*1.0: P=48'h4000_0000_0000, exp=127, RNE
//    -> fract=24'h800000, exp=127, inexact=0, 2 cycles later.
//  - Round carry: P=48'h7FFF_FFC0_0000, exp=100, RNE
//    -> fract=24'h800000, exp=101, inexact=1.
//  - Tie: P=48'h8000_0080_0000, sign=0, exp=50
//    -> RNE fract=24'h800000, exp=51; RUP fract=24'h800001; RTZ fract=24'h800000; all inexact=1.
//  - Backpressure: iDATA_BUSY=1 with 3 back-to-back inputs
//    -> the first 2 are accepted, then oDATA_BUSY=1 and the outputs hold.
//    -> After release, the 3 results arrive in order, one per clock, with none lost or duplicated.
//  - Exp wrap: exp=10'h3FF, P[47]=1 -> exp=10'h000.
//  - Reset with both stages full -> next cycle oDATA_VALID=0 and all outputs 0.

Source files
------------

// File: rtl/mul_float_normalize_round_pipe.sv
// Two-stage normalize/round stage of the float multiplier: stage 1 normalizes the raw
// product by at most one bit, stage 2 rounds in the per-transaction mode. Valid/busy with bubble collapse.
module mul_float_normalize_round_pipe #(
  parameter int FRACT_W  = 24,
  parameter int EXP_W    = 10,
  parameter int EXCEPT_W = 6
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET_SYNC,
  input  logic                  iDATA_VALID,
  output logic                  oDATA_BUSY,
  input  logic                  iDATA_SIGN,
  input  logic [EXP_W-1:0]      iDATA_EXP,
  input  logic [2*FRACT_W-1:0]  iDATA_FRACT,
  input  logic [2:0]            iDATA_RMODE,
  input  logic [EXCEPT_W-1:0]   iDATA_EXCEPT,
  output logic                  oDATA_VALID,
  input  logic                  iDATA_BUSY,
  output logic                  oDATA_SIGN,
  output logic [EXP_W-1:0]      oDATA_EXP,
  output logic [FRACT_W-1:0]    oDATA_FRACT,
  output logic                  oDATA_INEXACT,
  output logic [EXCEPT_W-1:0]   oDATA_EXCEPT
);

  localparam int PW = 2 * FRACT_W;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_t;

  // Stage registers
  logic                s1_valid, s2_valid;
  logic                s1_sign;
  logic [EXP_W-1:0]    s1_exp;
  logic [FRACT_W-1:0]  s1_sig;
  logic                s1_l, s1_g, s1_s;
  logic [2:0]          s1_rmode;
  logic [EXCEPT_W-1:0] s1_except;

  logic                s2_sign;
  logic [EXP_W-1:0]    s2_exp;
  logic [FRACT_W-1:0]  s2_fract;
  logic                s2_inexact;
  logic [EXCEPT_W-1:0] s2_except;

  logic s1_en, s2_en;

  // An empty s2 always accepts, so a bubble collapses even while downstream is busy.
  assign s2_en      = !s2_valid || !iDATA_BUSY;
  assign s1_en      = !s1_valid || s2_en;
  assign oDATA_BUSY = !s1_en;

  // Stage 1 next-state: one-bit normalization
  logic [FRACT_W-1:0] n_sig;
  logic [EXP_W-1:0]   n_exp;
  logic               n_l, n_g, n_s;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    n_sig = iDATA_FRACT[PW-2:FRACT_W-1];
    n_l   = iDATA_FRACT[FRACT_W-1];
    n_g   = iDATA_FRACT[FRACT_W-2];
    n_s   = |iDATA_FRACT[FRACT_W-3:0];
    n_exp = iDATA_EXP;
    if (iDATA_FRACT[PW-1]) begin
      n_sig = iDATA_FRACT[PW-1:FRACT_W];
      n_l   = iDATA_FRACT[FRACT_W];
      n_g   = iDATA_FRACT[FRACT_W-1];
      n_s   = |iDATA_FRACT[FRACT_W-2:0];
      n_exp = iDATA_EXP + EXP_W'(1);
    end
  end

  // Stage 2 next-state: rounding increment and carry renormalization
  logic               inc;
  logic [FRACT_W:0]   sum;
  logic [FRACT_W-1:0] r_fract;
  logic [EXP_W-1:0]   r_exp;

  always_comb begin
    case (s1_rmode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign && (s1_g || s1_s);
      RM_RUP:  inc = !s1_sign && (s1_g || s1_s);
      RM_RMM:  inc = s1_g;
      default: inc = s1_g && (s1_l || s1_s);
    endcase
    sum     = {1'b0, s1_sig} + (FRACT_W+1)'(inc);
    r_fract = sum[FRACT_W-1:0];
    r_exp   = s1_exp;
    if (sum[FRACT_W]) begin
      r_fract = {1'b1, {(FRACT_W-1){1'b0}}};
      r_exp   = s1_exp + EXP_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      // NOTE: data registers are reset too, so every output reads 0 after reset.
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_sig     <= '0;
      s1_l       <= 1'b0;
      s1_g       <= 1'b0;
      s1_s       <= 1'b0;
      s1_rmode   <= '0;
      s1_except  <= '0;
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_exp     <= '0;
      s2_fract   <= '0;
      s2_inexact <= 1'b0;
      s2_except  <= '0;
    end else begin
      if (s1_en) begin
        s1_valid  <= iDATA_VALID;
        s1_sign   <= iDATA_SIGN;
        s1_exp    <= n_exp;
        s1_sig    <= n_sig;
        s1_l      <= n_l;
        s1_g      <= n_g;
        s1_s      <= n_s;
        s1_rmode  <= iDATA_RMODE;
        s1_except <= iDATA_EXCEPT;
      end
      if (s2_en) begin
        s2_valid   <= s1_valid;
        s2_sign    <= s1_sign;
        s2_exp     <= r_exp;
        s2_fract   <= r_fract;
        s2_inexact <= s1_g || s1_s;
        s2_except  <= s1_except;
      end
    end
  end

  assign oDATA_VALID   = s2_valid;
  assign oDATA_SIGN    = s2_sign;
  assign oDATA_EXP     = s2_exp;
  assign oDATA_FRACT   = s2_fract;
  assign oDATA_INEXACT = s2_inexact;
  assign oDATA_EXCEPT  = s2_except;

endmodule

// File: tb/tb_mul_float_normalize_round_pipe.sv
// Bench for the normalize/round stage: arithmetic rounding model + scoreboard checked at
// every output handshake, hold checks under backpressure, and literal checks from hand-worked cases.
module tb_mul_float_normalize_round_pipe;

  localparam int F  = 24;
  localparam int EW = 10;
  localparam int XW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_busy_o, in_sign;
  logic [EW-1:0]   in_exp;
  logic [2*F-1:0]  in_fract;
  logic [2:0]      in_rmode;
  logic [XW-1:0]   in_except;
  logic            out_valid, out_busy_i, out_sign, out_inexact;
  logic [EW-1:0]   out_exp;
  logic [F-1:0]    out_fract;
  logic [XW-1:0]   out_except;

  always #5 clk = ~clk;

  mul_float_normalize_round_pipe #(.FRACT_W(F), .EXP_W(EW), .EXCEPT_W(XW)) dut (
    .iCLOCK        (clk),
    .iRESET_SYNC   (rst),
    .iDATA_VALID   (in_valid),
    .oDATA_BUSY    (in_busy_o),
    .iDATA_SIGN    (in_sign),
    .iDATA_EXP     (in_exp),
    .iDATA_FRACT   (in_fract),
    .iDATA_RMODE   (in_rmode),
    .iDATA_EXCEPT  (in_except),
    .oDATA_VALID   (out_valid),
    .iDATA_BUSY    (out_busy_i),
    .oDATA_SIGN    (out_sign),
    .oDATA_EXP     (out_exp),
    .oDATA_FRACT   (out_fract),
    .oDATA_INEXACT (out_inexact),
    .oDATA_EXCEPT  (out_except)
  );

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [F-1:0]  fract;
    logic          inexact;
    logic [XW-1:0] exc;
  } res_t;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Rounding done on the numeric value: keep the top F bits of the product, compare the
  // discarded remainder against half an ulp.
  function automatic res_t model(input logic s, input logic [EW-1:0] e, input logic [2*F-1:0] p,
                                 input logic [2:0] rm, input logic [XW-1:0] x);
    res_t            r;
    longint unsigned pv, sig, rem, half;
    int              sh, en;
    bit              up;
    pv   = 64'(p);
    sh   = (pv >= (64'd1 << (2*F-1))) ? F : F-1;
    sig  = pv >> sh;
    rem  = pv - (sig << sh);
    half = 64'd1 << (sh-1);
    en   = int'(e) + ((sh == F) ? 1 : 0);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (rem != 0);
      3'd3:    up = !s && (rem != 0);
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || (rem == half && (sig % 2) == 1);
    endcase
    sig = sig + (up ? 64'd1 : 64'd0);
    if (sig == (64'd1 << F)) begin
      sig = 64'd1 << (F-1);
      en  = en + 1;
    end
    r.sign    = s;
    r.exp     = en[EW-1:0];
    r.fract   = sig[F-1:0];
    r.inexact = (rem != 0);
    r.exc     = x;
    return r;
  endfunction

  function automatic res_t dut_out();
    res_t r;
    r.sign    = out_sign;
    r.exp     = out_exp;
    r.fract   = out_fract;
    r.inexact = out_inexact;
    r.exc     = out_except;
    return r;
  endfunction

  // Compare process: both handshakes are decided at negedge for the following posedge.
  res_t q[$];
  res_t held;
  bit   holding = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      holding = 1'b0;
    end else begin
      if (holding) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(dut_out()), 64'(held));
      end
      holding = out_valid && out_busy_i;
      if (holding) held = dut_out();
      if (out_valid && !out_busy_i) begin
        check("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          res_t exp_r;
          exp_r = q.pop_front();
          check("output", 64'(dut_out()), 64'(exp_r));
        end
        n_out++;
      end
      if (in_valid && !in_busy_o)
        q.push_back(model(in_sign, in_exp, in_fract, in_rmode, in_except));
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic s, input logic [EW-1:0] e, input logic [2*F-1:0] p,
                      input logic [2:0] rm, input logic [XW-1:0] x);
    int t = 0;
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_fract  = p;
    in_rmode  = rm;
    in_except = x;
    @(negedge clk);
    while (in_busy_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("send_timeout", 64'(in_busy_o), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_data"}, 64'(dut_out()), 64'd0);
  endtask

  logic [2*F-1:0] ptab [5];
  res_t m;
  int   base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_fract = '0;
    in_rmode = '0; in_except = '0; out_busy_i = 1'b0;
    ptab[0] = 48'h0;
    ptab[1] = 48'hFFFF_FFFF_FFFF;
    ptab[2] = 48'h5555_5555_5555;
    ptab[3] = 48'h8000_0180_0001;
    ptab[4] = 48'h4000_00C0_0000;

    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    check("reset_busy", 64'(in_busy_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Model pinned against hand-worked cases
    m = model(1'b0, 10'd100, 48'h7FFF_FFC0_0000, 3'd0, 6'd0);
    check("pin_carry_fract", 64'(m.fract), 64'h800000);
    check("pin_carry_exp", 64'(m.exp), 64'd101);
    check("pin_carry_inexact", 64'(m.inexact), 64'd1);
    m = model(1'b0, 10'd50, 48'h8000_0080_0000, 3'd0, 6'd0);
    check("pin_tie_rne", 64'({m.exp, m.fract, m.inexact}), 64'({10'd51, 24'h800000, 1'b1}));
    m = model(1'b0, 10'd50, 48'h8000_0080_0000, 3'd3, 6'd0);
    check("pin_tie_rup", 64'(m.fract), 64'h800001);
    m = model(1'b0, 10'd50, 48'h8000_0080_0000, 3'd1, 6'd0);
    check("pin_tie_rtz", 64'(m.fract), 64'h800000);
    m = model(1'b0, 10'h3FF, 48'h8000_0000_0000, 3'd0, 6'd0);
    check("pin_wrap_exp", 64'(m.exp), 64'h000);
    m = model(1'b1, 10'd77, 48'h0, 3'd3, 6'd0);
    check("pin_zero", 64'({m.exp, m.fract, m.inexact}), 64'({10'd77, 24'h0, 1'b0}));

    // 1.0*1.0: two-cycle latency
    send(1'b0, 10'd127, 48'h4000_0000_0000, 3'd0, 6'h15);
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    check("one_fract", 64'(out_fract), 64'h800000);
    check("one_exp", 64'(out_exp), 64'd127);
    check("one_inexact", 64'(out_inexact), 64'd0);
    check("one_except", 64'(out_except), 64'h15);

    // Remaining literal cases through the DUT (scoreboard checks the values)
    send(1'b0, 10'd100, 48'h7FFF_FFC0_0000, 3'd0, 6'd1);
    send(1'b0, 10'd50, 48'h8000_0080_0000, 3'd0, 6'd2);
    send(1'b0, 10'd50, 48'h8000_0080_0000, 3'd3, 6'd3);
    send(1'b0, 10'd50, 48'h8000_0080_0000, 3'd1, 6'd4);
    send(1'b0, 10'h3FF, 48'h8000_0000_0000, 3'd0, 6'd5);
    @(posedge clk); #1;
    check("wrap_dut_exp", 64'(out_exp), 64'h000);
    repeat (3) @(posedge clk); #1;

    // Backpressure: two accepted, third stalls, outputs hold, then all three drain in order
    out_busy_i = 1'b1;
    base = n_out;
    fork
      begin
        send(1'b0, 10'd1, 48'h6000_0000_0000, 3'd0, 6'h0A);
        send(1'b0, 10'd50, 48'h8000_0080_0000, 3'd3, 6'h0B);
        send(1'b1, 10'd100, 48'h7FFF_FFC0_0000, 3'd2, 6'h0C);
      end
    join_none
    repeat (2) @(posedge clk); #1;
    check("bp_busy", 64'(in_busy_o), 64'd1);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_first_fract", 64'(out_fract), 64'hC00000);
    repeat (3) @(posedge clk); #1;
    check("bp_still_busy", 64'(in_busy_o), 64'd1);
    out_busy_i = 1'b0;
    wait fork;
    repeat (4) @(posedge clk); #1;
    check("bp_count", 64'(n_out - base), 64'd3);

    // Sweep of modes and products with random downstream stalls
    fork
      begin
        repeat (150) begin
          @(posedge clk); #1;
          out_busy_i = 1'($urandom_range(0, 1));
        end
        out_busy_i = 1'b0;
      end
    join_none
    for (int rm = 0; rm < 8; rm++)
      for (int i = 0; i < 5; i++)
        send(1'(i + rm), EW'(60 + 7*i + rm), ptab[i], 3'(rm), XW'(rm*5 + i));
    wait fork;
    out_busy_i = 1'b0;
    for (int t = 0; t < 50 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(q.size()), 64'd0);

    // Reset with both stages full drops everything
    out_busy_i = 1'b1;
    send(1'b1, 10'd33, 48'hFFFF_FFFF_FFFF, 3'd4, 6'h3F);
    send(1'b1, 10'd34, 48'h5555_5555_5555, 3'd3, 6'h2A);
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_busy", 64'(in_busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("midreset");
    check("midreset_busy", 64'(in_busy_o), 64'd0);
    out_busy_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("midreset_no_output", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
